adder_share_arb: RTL

ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

---
 rtl/adder_share_pkg.sv | 30 +++
 rtl/adder_share_arb_add_core.sv | 42 ++++
 rtl/adder_share_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// Shared defaults and helpers for the adder_share_arb slice.
// The optional carry-in feature of this slice is selected with ADD_SHARE_CIN_EN.
package adder_share_pkg;

  localparam int ADD_SHARE_WIDTH = 18;
  localparam int ADD_SHARE_NREQ  = 4;
  localparam int ADD_SHARE_BLK_W = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int add_share_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Look-ahead carry into bit 'pos' of a 4-bit block from its generate/propagate terms.
  function automatic logic cla_carry(input logic [3:0] g,
                                     input logic [3:0] p,
                                     input logic       ci,
                                     input int         pos);
    logic c;
    logic pp;
    c  = 1'b0;
    pp = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      c  = (k < pos) ? (c | (g[k] & pp)) : c;
      pp = (k < pos) ? (pp & p[k]) : pp;
    end
    return c | (pp & ci);
  endfunction

endpackage

// File: rtl/adder_share_arb_add_core.sv
// Combinational WIDTH-bit adder: 4-bit carry look-ahead blocks (plus a narrower
// remainder block) chained block-to-block; sum MSB is the carry-out.
module add_core
  import adder_share_pkg::*;
#(
  parameter int WIDTH = ADD_SHARE_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   sum_o
);

  localparam int NBLK = (WIDTH + ADD_SHARE_BLK_W - 1) / ADD_SHARE_BLK_W;

  for (genvar blk = 0; blk < NBLK; blk++) begin : g_blk
    localparam int LO = blk * ADD_SHARE_BLK_W;
    localparam int BW = ((WIDTH - LO) < ADD_SHARE_BLK_W) ? (WIDTH - LO) : ADD_SHARE_BLK_W;

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic       ci_s;
    logic       co_s;

    if (blk == 0) begin : g_first
      assign ci_s = cin_i;
    end else begin : g_chain
      assign ci_s = g_blk[blk-1].co_s;
    end

    assign g_s  = 4'(a_i[LO +: BW] & b_i[LO +: BW]);
    assign p_s  = 4'(a_i[LO +: BW] | b_i[LO +: BW]);
    assign co_s = cla_carry(g_s, p_s, ci_s, BW);

    for (genvar j = 0; j < BW; j++) begin : g_bit
      assign sum_o[LO + j] = a_i[LO + j] ^ b_i[LO + j] ^ cla_carry(g_s, p_s, ci_s, j);
    end
  end

  assign sum_o[WIDTH] = g_blk[NBLK-1].co_s;

endmodule

// File: rtl/adder_share_arb.sv
// NREQ requesters share one add_core through a round-robin arbiter feeding a
// single registered result slot. Define ADD_SHARE_CIN_EN to add per-requester carry-in.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int NREQ  = ADD_SHARE_NREQ,
  parameter int WIDTH = ADD_SHARE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*WIDTH-1:0]           req_a,
  input  logic [NREQ*WIDTH-1:0]           req_b,
`ifdef ADD_SHARE_CIN_EN
  input  logic [NREQ-1:0]                 req_cin,
`endif
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH:0]                  out_sum,
  output logic [add_share_id_w(NREQ)-1:0] out_id
);

  localparam int IDW = add_share_id_w(NREQ);

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH:0]   out_sum_q;
  logic [WIDTH:0]   out_sum_d;
  logic [IDW-1:0]   out_id_q;
  logic [IDW-1:0]   out_id_d;

  logic [NREQ-1:0]  vrot_s;
  int               gnt_off_s;
  int               gnt_pos_s;
  logic             gnt_any_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [NREQ-1:0]  gnt_oh_s;
  logic             slot_free_s;
  logic             xfer_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic             cin_sel_s;
  logic [WIDTH:0]   sum_s;

  assign slot_free_s = !out_valid_q || out_ready;

  // Round-robin pick: rotate valids so the pointer sits at bit 0, take lowest set bit.
  always_comb begin
    vrot_s    = NREQ'({req_valid, req_valid} >> ptr_q);
    gnt_any_s = |vrot_s;
    gnt_off_s = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      gnt_off_s = vrot_s[off] ? off : gnt_off_s;
    end
    gnt_pos_s = int'(ptr_q) + gnt_off_s;
    gnt_pos_s = (gnt_pos_s >= NREQ) ? (gnt_pos_s - NREQ) : gnt_pos_s;
    gnt_idx_s = IDW'(gnt_pos_s);
    gnt_oh_s  = gnt_any_s ? (NREQ'(1) << gnt_idx_s) : '0;
  end

  assign xfer_s    = slot_free_s && gnt_any_s;
  assign req_ready = xfer_s ? gnt_oh_s : '0;

  // AND-OR operand mux keyed by the one-hot grant.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel_s = a_sel_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{gnt_oh_s[i]}});
      b_sel_s = b_sel_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{gnt_oh_s[i]}});
    end
`ifdef ADD_SHARE_CIN_EN
    cin_sel_s = |(req_cin & gnt_oh_s);
`else
    cin_sel_s = 1'b0;
`endif
  end

  add_core #(
    .WIDTH (WIDTH)
  ) u_add_core (
    .a_i   (a_sel_s),
    .b_i   (b_sel_s),
    .cin_i (cin_sel_s),
    .sum_o (sum_s)
  );

  // Result slot and pointer next-state: load on transfer, drain on consumer accept.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_s;
      out_id_d    = gnt_idx_s;
      ptr_d       = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : (gnt_idx_s + IDW'(1));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset drops any pending result and restores requester 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;

endmodule
